// File: rtl/k3_mac_acc.sv
// k3_mac_acc: per-lane signed MAC over TAPS x CH_IN samples with rounded, saturated 16-bit output.
// Optional build macro K3_MAC_RELU_EN: clamp negative lane results to zero after saturation.
module k3_mac_acc #(
  parameter int NUM_LANE = 36,
  parameter int TAPS     = 36,
  parameter int CH_IN    = 6,
  parameter int DW       = 16,
  parameter int ACC_W    = 40,
  parameter int FRAC     = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   din_valid,
  input  logic signed [DW-1:0]   din,
  input  logic [NUM_LANE*DW-1:0] k_bus,
  output logic                   busy,
  output logic                   tap_last,
  output logic                   dout_valid,
  output logic [NUM_LANE*DW-1:0] dout,
  output logic                   dout_sat
);
  localparam int TW = $clog2(TAPS);
  localparam int CW = $clog2(CH_IN);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(2 ** (DW - 1) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = -SMAX - ACC_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [TW-1:0]            tap_cnt;
  logic [CW-1:0]            ch_cnt;
  logic signed [2*DW-1:0]   prod [NUM_LANE];
  logic                     prod_v;
  logic                     prod_last;
  logic signed [ACC_W-1:0]  acc [NUM_LANE];
  logic                     acc_done;
  logic signed [ACC_W-1:0]  rnd [NUM_LANE];
  logic [NUM_LANE*DW-1:0]   res;
  logic [NUM_LANE-1:0]      sat;
  logic                     tap_end;
  logic                     last_s;

  assign tap_end  = tap_cnt == TW'(TAPS - 1);
  assign tap_last = tap_end;
  assign last_s   = din_valid && tap_end && ch_cnt == CW'(CH_IN - 1);
  assign busy     = state != IDLE;

  // Sample counters and pixel state; DONE exits on the edge that registers dout.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state   <= IDLE;
      tap_cnt <= '0;
      ch_cnt  <= '0;
    end else begin
      if (din_valid) begin
        tap_cnt <= tap_end ? '0 : tap_cnt + TW'(1);
        if (tap_end) ch_cnt <= (ch_cnt == CW'(CH_IN - 1)) ? '0 : ch_cnt + CW'(1);
      end
      state <= (state == IDLE) ? (din_valid ? RUN : IDLE)
             : (state == RUN)  ? (last_s ? DONE : RUN)
             : !acc_done       ? DONE
             : (din_valid || tap_cnt != '0 || ch_cnt != '0) ? RUN : IDLE;
    end
  end

  // Product stage: one signed multiply per lane, tagged with valid and end-of-pixel.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      prod_v    <= 1'b0;
      prod_last <= 1'b0;
      for (int i = 0; i < NUM_LANE; i++) prod[i] <= '0;
    end else begin
      prod_v    <= din_valid;
      prod_last <= last_s;
      for (int i = 0; i < NUM_LANE; i++) prod[i] <= din * $signed(k_bus[i*DW +: DW]);
    end
  end

  // Accumulate; on the output edge restart from the next pixel's pending product.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      acc_done <= 1'b0;
      for (int i = 0; i < NUM_LANE; i++) acc[i] <= '0;
    end else begin
      acc_done <= prod_v && prod_last;
      for (int i = 0; i < NUM_LANE; i++)
        acc[i] <= acc_done ? (prod_v ? ACC_W'(prod[i]) : '0)
                : prod_v   ? acc[i] + ACC_W'(prod[i]) : acc[i];
    end
  end

  // Round half up, arithmetic shift, saturate to DW bits.
  always_comb begin
    res = '0;
    sat = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      rnd[i] = (acc[i] + HALF) >>> FRAC;
      sat[i] = rnd[i] > SMAX || rnd[i] < SMIN;
      res[i*DW +: DW] = rnd[i] > SMAX ? SMAX[DW-1:0] : rnd[i] < SMIN ? SMIN[DW-1:0] : rnd[i][DW-1:0];
`ifdef K3_MAC_RELU_EN
      if (res[i*DW + DW - 1]) res[i*DW +: DW] = '0;
`endif
    end
  end

  // Output register: dout holds between one-cycle dout_valid pulses.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_sat   <= 1'b0;
    end else begin
      dout_valid <= acc_done;
      if (acc_done) begin
        dout     <= res;
        dout_sat <= |sat;
      end
    end
  end
endmodule
